uart_receiver: RTL

//   Serial-to-parallel UART receiver; receive-side counterpart of core_transmitter on the PL UART link.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_receiver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and line idle level.
package uart_pkg;

   localparam logic LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to all ones (idle level of UART lines).
module uart_rx_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver, LSB-first framing, push interface to a byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE       = 115200,
   parameter int WORD_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rxd,
   input  logic                  full,
   output logic                  we,
   output logic [WORD_WIDTH-1:0] dout,
   output logic                  frame_err,
   output logic                  overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORD_WIDTH - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_cfg_check
         $error("uart_receiver: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   rx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic                  rxd_s;
   logic                  sample;
`ifdef UART_RX_PARITY_EN
   logic                  parity_bad;
`endif

   uart_rx_sync #(
      .WIDTH (1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign sample = (cnt == '0);

   // Bits arrive LSB first, so each new bit enters at the MSB and moves down.
   function automatic logic [WORD_WIDTH-1:0] shift_lsb_first(input logic [WORD_WIDTH-1:0] sr,
                                                             input logic              b);
      logic [WORD_WIDTH-1:0] r;
      r                 = sr >> 1;
      r[WORD_WIDTH-1]   = b;
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         dout       <= '0;
         we         <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         we        <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (rxd_s != LINE_IDLE) begin
                  state <= START;
                  cnt   <= HALF_RELOAD;
               end
            end
            // Re-check at mid start bit rejects short glitches without flagging them.
            START: begin
               if (!sample) begin
                  cnt <= cnt - 1'b1;
               end else if (rxd_s != LINE_IDLE) begin
                  state   <= DATA;
                  cnt     <= BIT_RELOAD;
                  bit_idx <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (!sample) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shift_reg <= shift_lsb_first(shift_reg, rxd_s);
                  cnt       <= BIT_RELOAD;
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
               if (!sample) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  parity_bad <= (^shift_reg) ^ rxd_s;
                  cnt        <= BIT_RELOAD;
                  state      <= STOP;
               end
`else
               state <= IDLE;
`endif
            end
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            STOP: begin
               if (!sample) begin
                  cnt <= cnt - 1'b1;
               end else if (rxd_s != LINE_IDLE) begin
                  frame_err <= 1'b1;
                  state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
               end else if (parity_bad) begin
                  parity_err <= 1'b1;
                  state      <= IDLE;
`endif
               end else if (full) begin
                  overrun <= 1'b1;
                  state   <= IDLE;
               end else begin
                  dout  <= shift_reg;
                  we    <= 1'b1;
                  state <= IDLE;
               end
            end
            // A break or stuck-low line must not be read as a stream of new frames.
            WAIT_HIGH: begin
               if (rxd_s == LINE_IDLE) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
